real_mul_byte_loader: RTL

//  Byte-serial front/back end for the real_mul multiplier. Assembles op1/op2 from an 8-bit

---
 rtl/real_mul_byte_loader_if.sv | 24 ++
 rtl/real_mul_byte_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/real_mul_byte_loader_if.sv
// Byte-stream and multiplier-side bus for real_mul_byte_loader.
// slave = loader side, master = stream source/sink plus multiplier side.
interface real_mul_byte_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [63:0] op1;
  logic [63:0] op2;
  logic [63:0] mul_result;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;

  modport slave (
    input  in_valid, in_data, mul_result, out_ready,
    output in_ready, op1, op2, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, mul_result, out_ready,
    input  in_ready, op1, op2, out_valid, out_data, busy
  );
endinterface

// File: rtl/real_mul_byte_loader.sv
// Byte-serial loader/streamer around real_mul: assembles op1/op2, waits RES_LAT+1 cycles,
// streams the product MSB-first. Define REAL_MUL_LOADER_CKSUM_EN to append an XOR checksum byte.
module real_mul_byte_loader #(
  parameter int IS_DOUBLE = 0,
  parameter int RES_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  real_mul_byte_loader_if.slave bus
);
  localparam int N = (IS_DOUBLE != 0) ? 8 : 4;
  localparam int W = 8 * N;
`ifdef REAL_MUL_LOADER_CKSUM_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  localparam logic [3:0] N_LAST   = 4'(N - 1);
  localparam logic [3:0] IDX_LAST = 4'(NB - 1);
  localparam logic [3:0] LAT_LAST = 4'(RES_LAT);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT_LAT, SEND} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [3:0]  wait_reg;
  logic [3:0]  idx_reg;
  logic [63:0] op1_reg;
  logic [63:0] op2_reg;
  logic [W-1:0] res_reg;
  logic        out_valid_reg;
  logic [7:0]  out_data_reg;

  logic [W-1:0] cap;
  logic         in_ready;
  logic         accept;
  logic [7:0]   send_bytes [16];

  function automatic logic [63:0] shift_in(input logic [63:0] op, input logic [7:0] b);
    return (IS_DOUBLE != 0) ? {op[55:0], b} : {32'b0, op[23:0], b};
  endfunction

  assign cap      = bus.mul_result[W-1:0];
  assign in_ready = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.op1       = op1_reg;
  assign bus.op2       = op2_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.busy      = (state_reg != LOAD_A) || (cnt_reg != 4'd0);

`ifdef REAL_MUL_LOADER_CKSUM_EN
  logic [7:0] cksum;
  always_comb begin
    cksum = 8'h00;
    for (int i = 0; i < N; i++) cksum = cksum ^ res_reg[8*i +: 8];
  end
`endif

  // Output bytes laid out in transmit order; slot N holds the checksum when enabled.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_send
      if (gi < N) begin : g_res
        assign send_bytes[gi] = res_reg[8*(N-1-gi) +: 8];
      end
`ifdef REAL_MUL_LOADER_CKSUM_EN
      else if (gi == N) begin : g_ck
        assign send_bytes[gi] = cksum;
      end
`endif
      else begin : g_pad
        assign send_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= LOAD_A;
      cnt_reg       <= 4'd0;
      wait_reg      <= 4'd0;
      idx_reg       <= 4'd0;
      op1_reg       <= 64'd0;
      op2_reg       <= 64'd0;
      res_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
    end else begin
      case (state_reg)
        LOAD_A: if (accept) begin
          op1_reg <= shift_in(op1_reg, bus.in_data);
          if (cnt_reg == N_LAST) begin
            cnt_reg   <= 4'd0;
            state_reg <= LOAD_B;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        LOAD_B: if (accept) begin
          op2_reg <= shift_in(op2_reg, bus.in_data);
          if (cnt_reg == N_LAST) begin
            cnt_reg   <= 4'd0;
            wait_reg  <= 4'd0;
            state_reg <= WAIT_LAT;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        WAIT_LAT: begin
          // First output byte comes straight from the multiplier so it is valid on SEND entry.
          if (wait_reg == LAT_LAST) begin
            res_reg       <= cap;
            out_valid_reg <= 1'b1;
            out_data_reg  <= cap[W-1 -: 8];
            idx_reg       <= 4'd0;
            state_reg     <= SEND;
          end else begin
            wait_reg <= wait_reg + 4'd1;
          end
        end
        SEND: if (bus.out_ready) begin
          if (idx_reg == IDX_LAST) begin
            out_valid_reg <= 1'b0;
            state_reg     <= LOAD_A;
          end else begin
            idx_reg      <= idx_reg + 4'd1;
            out_data_reg <= send_bytes[idx_reg + 4'd1];
          end
        end
        default: state_reg <= LOAD_A;
      endcase
    end
  end
endmodule
